// File: rtl/gray2rgb_frame_sequencer_pkg.sv
// Shared types for the grayscale-to-RGB frame sequencer: FSM encoding and RGB packing.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package gray2rgb_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam int PIX_W = 8;
    localparam int RGB_W = 3 * PIX_W;

    // Field order fixes the packing: red lands in the MSBs, blue in the LSBs.
    typedef struct packed {
        logic [PIX_W-1:0] red;
        logic [PIX_W-1:0] green;
        logic [PIX_W-1:0] blue;
    } rgb_t;

    function automatic rgb_t pack_rgb(input logic [PIX_W-1:0] r,
                                      input logic [PIX_W-1:0] g,
                                      input logic [PIX_W-1:0] b);
        rgb_t p;
        p.red   = r;
        p.green = g;
        p.blue  = b;
        return p;
    endfunction

endpackage

// File: rtl/gray2rgb_frame_sequencer_if.sv
// Bus bundle between the sequencer, frame memory, converter and output memory.
// Latency: n/a (wires only).
// Backpressure: wr_ready from output memory; reads and converter are never stalled.
// master = sequencer side, slave = memory/converter side.
interface gray2rgb_frame_sequencer_if #(
    parameter int ADDR_W = 19
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [7:0]        conv_gray;
    logic              conv_valid;
    logic [7:0]        conv_red;
    logic [7:0]        conv_green;
    logic [7:0]        conv_blue;
    logic              conv_done;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              wr_ready;

    modport master (
        output rd_en, rd_addr, conv_gray, conv_valid, wr_en, wr_addr, wr_data,
        input  rd_data, conv_red, conv_green, conv_blue, conv_done, wr_ready
    );

    modport slave (
        input  rd_en, rd_addr, conv_gray, conv_valid, wr_en, wr_addr, wr_data,
        output rd_data, conv_red, conv_green, conv_blue, conv_done, wr_ready
    );
endinterface

// File: rtl/gray2rgb_frame_sequencer_fifo.sv
// Synchronous result FIFO holding converted RGB words until output memory accepts them.
// Latency: 1 cycle push-to-head (head read from the storage array, visible after the push edge).
// Backpressure: none internally; the caller's credit scheme keeps push off a full FIFO.
// Ports: clk/rst_n, push/push_dat in, pop in, head_dat/cnt/empty out.
module seq_result_fifo #(
    parameter  int W     = 24,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] cnt,
    output logic             empty
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_W'(DEPTH));

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/gray2rgb_frame_sequencer.sv
// Frame controller: streams IMG_W*IMG_H gray pixels through the converter into output memory.
// Latency: first write RD_LAT+CONV_LAT+1 cycles after first read; 1 pixel/cycle when wr_ready held.
// Backpressure: wr_ready stalls the result FIFO; reads stop once inflight+FIFO occupancy hits FIFO_D.
// Ports: clk/rst_n, start_i/busy_o/frame_done_o control, bus (master) to memories and converter.
module gray2rgb_frame_sequencer
    import gray2rgb_frame_sequencer_pkg::*;
#(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int ADDR_W   = 19,
    parameter int RD_LAT   = 1,
    parameter int CONV_LAT = 1,
    parameter int FIFO_D   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       frame_done_o,
    gray2rgb_frame_sequencer_if.master bus
);
    localparam int N     = IMG_W * IMG_H;
    localparam int CNT_W = ADDR_W + 1;
    localparam int CR_W  = $clog2(FIFO_D + 1);
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] rd_cnt, wr_cnt;
    logic [CR_W-1:0]  inflight, fifo_cnt;
    logic [CR_W:0]    credits_used;
    logic [RD_LAT-1:0] vld_sr;
    logic             in_frame, issue, push, pop, fifo_empty;
    rgb_t             head;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i)         state_d = ST_RUN;
            ST_RUN:   if (rd_cnt == N_CNT) state_d = ST_DRAIN;
            ST_DRAIN: if (wr_cnt == N_CNT) state_d = ST_DONE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. busy drops in the same cycle frame_done pulses.
    always_comb begin
        in_frame     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        busy_o       = in_frame;
        frame_done_o = (state_q == ST_DONE);
    end

    // A read may only be issued if its result is guaranteed a FIFO slot, so the
    // FIFO never needs to push back on the converter.
    assign credits_used = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign issue = (state_q == ST_RUN) && (rd_cnt < N_CNT)
                && (credits_used < (CR_W + 1)'(FIFO_D));
    assign push  = bus.conv_done && in_frame;
    assign pop   = bus.wr_en && bus.wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            inflight <= '0;
        end else if ((state_q == ST_IDLE) && start_i) begin
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            inflight <= '0;
        end else begin
            if (issue) rd_cnt <= rd_cnt + 1'b1;
            if (pop)   wr_cnt <= wr_cnt + 1'b1;
            case ({issue, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Read strobe delayed by the memory latency marks the cycle rd_data is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
        end
    end

    // Memory data is forwarded in its valid cycle without another register so the
    // first write lands RD_LAT+CONV_LAT+1 cycles after the first read.
    assign bus.conv_valid = vld_sr[RD_LAT-1];
    assign bus.conv_gray  = bus.conv_valid ? bus.rd_data : 8'd0;
    assign bus.rd_en      = issue;
    assign bus.rd_addr    = issue ? rd_cnt[ADDR_W-1:0] : '0;

    seq_result_fifo #(
        .W     (RGB_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (pack_rgb(bus.conv_red, bus.conv_green, bus.conv_blue)),
        .pop      (pop),
        .head_dat (head),
        .cnt      (fifo_cnt),
        .empty    (fifo_empty)
    );

    assign bus.wr_en   = !fifo_empty;
    assign bus.wr_addr = bus.wr_en ? wr_cnt[ADDR_W-1:0] : '0;
    assign bus.wr_data = bus.wr_en ? head : '0;

    a_fifo_depth: assert property (@(posedge clk) FIFO_D >= RD_LAT + CONV_LAT + 1);

endmodule

// File: tb/tb_gray2rgb_frame_sequencer.sv
// Bench for gray2rgb_frame_sequencer on a 4x3 frame with gray[a]=a+1 and a
// replicating one-cycle converter model.
module tb_gray2rgb_frame_sequencer;
    localparam int IMG_W = 4, IMG_H = 3, N = 12, ADDR_W = 4;
    localparam int RD_LAT = 1, CONV_LAT = 1, FIFO_D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0;
    logic rdy = 1'b1;
    logic spur = 1'b0;
    logic busy_o, frame_done_o;

    gray2rgb_frame_sequencer_if #(.ADDR_W(ADDR_W)) bus();

    gray2rgb_frame_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT), .CONV_LAT(CONV_LAT), .FIFO_D(FIFO_D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Frame memory (1-cycle read) and converter (1-cycle, gray replicated to r/g/b).
    logic [7:0] mem_q = 8'd0;
    logic       done_q = 1'b0;
    logic [7:0] r_q = 8'd0, g_q = 8'd0, b_q = 8'd0;
    always @(posedge clk) begin
        if (bus.rd_en) mem_q <= 8'(bus.rd_addr) + 8'd1;
        done_q <= bus.conv_valid;
        r_q    <= bus.conv_gray;
        g_q    <= bus.conv_gray;
        b_q    <= bus.conv_gray;
    end
    assign bus.rd_data    = mem_q;
    assign bus.conv_done  = done_q | spur;
    assign bus.conv_red   = r_q;
    assign bus.conv_green = g_q;
    assign bus.conv_blue  = b_q;
    assign bus.wr_ready   = rdy;

    typedef struct {
        int mode;          // 0 ready high, 1 ready low rel 4..12, 2 random, 3 alternating
        int exp_done_rel;  // frame_done cycle relative to start cycle, -1 = don't care
        int exp_busy;      // busy cycles, -1 = don't care
        int exp_max_out;   // max reads issued minus writes done, -1 = don't care
        int exp_lat;       // first write cycle minus first read cycle, -1 = don't care
    } vec_t;

    int n_checks = 0, n_fail = 0;
    int k = 0, s_cyc;
    int n_rd, n_wr, n_wren, n_done, first_rd, first_wr, done_cyc;
    int busy_cnt, max_out, stable_viol, ord_err, busy_at_done;
    bit prev_stall, last_busy, last_rd;
    logic [ADDR_W-1:0] prev_addr;
    logic [23:0]       prev_data;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_rd = 0; n_wr = 0; n_wren = 0; n_done = 0; first_rd = -1; first_wr = -1;
        done_cyc = -1; busy_cnt = 0; max_out = 0; stable_viol = 0; ord_err = 0;
        busy_at_done = 0; prev_stall = 0; last_busy = 0; last_rd = 0;
    endtask

    function automatic int all_out();
        return int'(busy_o | frame_done_o | bus.rd_en | (|bus.rd_addr) | bus.conv_valid
                    | (|bus.conv_gray) | bus.wr_en | (|bus.wr_addr) | (|bus.wr_data));
    endfunction

    task automatic sample();
        int a;
        logic [7:0] px;
        last_busy = busy_o;
        last_rd   = bus.rd_en;
        if (bus.rd_en) begin
            n_rd++;
            if (first_rd < 0) first_rd = k;
        end
        if (bus.wr_en) n_wren++;
        if (prev_stall && !(bus.wr_en && bus.wr_addr == prev_addr && bus.wr_data == prev_data))
            stable_viol++;
        prev_stall = bus.wr_en && !rdy;
        prev_addr  = bus.wr_addr;
        prev_data  = bus.wr_data;
        if (bus.wr_en && rdy) begin
            a  = n_wr % N;
            px = 8'(a + 1);
            if (bus.wr_addr != ADDR_W'(a) || bus.wr_data != {px, px, px}) ord_err++;
            n_wr++;
            if (first_wr < 0) first_wr = k;
        end
        if (n_rd - n_wr > max_out) max_out = n_rd - n_wr;
        if (busy_o) busy_cnt++;
        if (frame_done_o) begin
            n_done++;
            done_cyc = k;
            if (busy_o) busy_at_done++;
        end
    endtask

    task automatic step(input bit rdy_v, input bit st_v);
        rdy = rdy_v;
        start_i = st_v;
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        k++;
    endtask

    function automatic bit ready_for(input int mode, input int rel);
        case (mode)
            0:       return 1'b1;
            1:       return !(rel >= 4 && rel <= 12);
            2:       return 1'($urandom_range(0, 1));
            default: return rel[0];
        endcase
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        clear_stats();
        s_cyc = k;
        for (int i = 0; i < 400 && n_done == 0; i++) step(ready_for(v.mode, i), i == 0);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_writes"}, n_wr, N);
        check({tag, "_order"}, ord_err, 0);
        check({tag, "_stable_stall"}, stable_viol, 0);
        check({tag, "_busy_at_done"}, busy_at_done, 0);
        check({tag, "_max_out_le_depth"}, int'(max_out <= FIFO_D), 1);
        if (v.exp_done_rel >= 0) check({tag, "_done_cycle"}, done_cyc - s_cyc, v.exp_done_rel);
        if (v.exp_busy >= 0)     check({tag, "_busy_cycles"}, busy_cnt, v.exp_busy);
        if (v.exp_max_out >= 0)  check({tag, "_max_out"}, max_out, v.exp_max_out);
        if (v.exp_lat >= 0)      check({tag, "_first_wr_lat"}, first_wr - first_rd, v.exp_lat);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check({tag, "_idle_after"}, all_out(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int d1, i;
        vecs[0] = '{0, 17, 16, 3, 3};
        vecs[1] = '{1, 26, 25, 4, 12};
        vecs[2] = '{2, -1, -1, -1, -1};
        vecs[3] = '{3, -1, -1, -1, -1};
        clear_stats();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_zero", all_out(), 0);
        rst_n = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("idle_outputs_zero", all_out(), 0);

        for (int vi = 0; vi < 4; vi++) run_frame(vecs[vi], $sformatf("v%0d", vi));

        // start held high: one frame per IDLE entry, restart the cycle after frame_done
        clear_stats();
        i = 0;
        while (n_done < 1 && i < 200) begin step(1'b1, 1'b1); i++; end
        d1 = done_cyc;
        step(1'b1, 1'b1);
        check("hold_idle_not_busy", int'(last_busy), 0);
        step(1'b1, 1'b1);
        check("hold_restart_rd_en", int'(last_rd), 1);
        while (n_done < 2 && i < 400) begin step(1'b1, 1'b1); i++; end
        check("hold_done_count", n_done, 2);
        check("hold_frame_period", done_cyc - d1, 18);
        check("hold_writes", n_wr, 2 * N);
        check("hold_order", ord_err, 0);
        repeat (4) step(1'b1, 1'b0);
        check("hold_no_third_frame", n_rd, 2 * N);

        // reset mid-frame after the 5th write
        clear_stats();
        i = 0;
        while (n_wr < 5 && i < 200) begin step(1'b1, i == 0); i++; end
        check("midrst_reached_5_writes", n_wr, 5);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs_zero", all_out(), 0);
        clear_stats();
        repeat (3) step(1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (3) step(1'b1, 1'b0);
        check("midrst_no_done", n_done, 0);
        check("midrst_no_wr_en", n_wren, 0);
        run_frame(vecs[0], "midrst_restart");

        // spurious converter done while idle must not reach the FIFO
        clear_stats();
        spur = 1'b1;
        repeat (3) step(1'b1, 1'b0);
        spur = 1'b0;
        repeat (3) step(1'b1, 1'b0);
        check("spur_no_wr_en", n_wren, 0);
        run_frame(vecs[0], "spur_after");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
